opb_register_bank_ppc2simulink: RTL and testbench
=================================================

// Module: opb_register_bank_ppc2simulink
// PURPOSE
//  OPB slave exposing a bank of PPC-writable control registers plus read-only status words to
//  Simulink user logic, all on the OPB clock. Successor to the single-register software
//  register: N control words, byte-enable writes, readback, per-register write strobes,
//  self-clearing pulse bits. Sits on the control OPB bus beside the other ctl_regs slaves.
// PARAMETERS
//  C_BASEADDR     32'h01060000  first byte address of window
//  C_HIGHADDR     32'h010600FF  last byte address; window >= 4*(C_NUM_REGS+C_NUM_STATUS) bytes
//  C_OPB_AWIDTH   32            OPB address width (fixed 32)
//  C_OPB_DWIDTH   32            OPB data width (fixed 32)
//  C_NUM_REGS     4             control registers, 1..16
//  C_NUM_STATUS   2             read-only status words, 0..16
//  C_RESET_VAL    32'h00000000  reset value of every control register
//  C_PULSE_MASK   32'h00000000  bits of register 0 that self-clear one cycle after written 1
// PORTS
//  OPB_Clk         in   1                  single clock; all logic here
//  OPB_Rst_n       in   1                  synchronous active-low reset
//  OPB_ABus        in   [0:31]             byte address
//  OPB_BE          in   [0:3]              byte enables, BE[0] = DBus[0:7] = user bits 31:24
//  OPB_DBus        in   [0:31]             write data, DBus[0] = user bit 31
//  OPB_RNW         in   1                  1 read, 0 write
//  OPB_select      in   1                  transfer request
//  OPB_seqAddr     in   1                  ignored
//  Sl_DBus         out  [0:31]             read data, 0 when Sl_xferAck low
//  Sl_errAck       out  1                  tied 0
//  Sl_retry        out  1                  tied 0
//  Sl_toutSup      out  1                  tied 0
//  Sl_xferAck      out  1                  one-cycle transfer acknowledge
//  user_data_out   out  [32*C_NUM_REGS-1:0] control regs, reg k at [32k+31:32k]
//  user_wr_stb     out  [C_NUM_REGS-1:0]   1-cycle pulse, bit k when reg k written
//  user_status_in  in   [32*C_NUM_STATUS-1:0] status words, word j at [32j+31:32j]
// BEHAVIOUR
//  Reset (OPB_Rst_n=0 at edge, overrides all): FSM->IDLE; Sl_xferAck=0; Sl_DBus=0;
//   user_wr_stb=0; every control reg = C_RESET_VAL; aborts any transfer, no ack issued.
//  Hit = OPB_select & C_BASEADDR<=OPB_ABus<=C_HIGHADDR; word w = (ABus-C_BASEADDR)>>2;
//   ABus[30:31] ignored.
//  FSM IDLE -> ACK on hit; ACK -> WAIT always; WAIT -> IDLE when OPB_select=0.
//   Non-hit select leaves FSM in IDLE, no ack.
//  Latency: hit in cycle T -> Sl_xferAck=1 in T+1 only; never two acks per select assertion.
//  Write (RNW=0), w<C_NUM_REGS: at edge ending T, each byte with BE set is loaded from DBus;
//   new value on user_data_out in T+1; user_wr_stb[w]=1 in T+1 even if BE=0000.
//  Read (RNW=1): Sl_DBus in T+1 = reg w (w<C_NUM_REGS), status w-C_NUM_REGS sampled at end
//   of T (w<C_NUM_REGS+C_NUM_STATUS), else 0. Reads have no side effects.
//  Writes to status or unmapped words inside window: acked, no state change, no strobe.
//  C_PULSE_MASK: masked bits of reg 0 written 1 are high in T+1 only, 0 from T+2;
//   unmasked bits hold until rewritten.
//  Addr/data/BE/RNW sampled only in IDLE; changes during ACK/WAIT ignored.
//  Master holding select through WAIT: no further ack until select drops for >=1 cycle.
// TESTING
//  Reset: C_RESET_VAL=32'hA5A5_0000 -> all regs A5A50000, xferAck/stb 0, DBus 0.
//  Write 0xDEADBEEF to base+0x8, BE=1111 -> ack T+1, reg2=DEADBEEF, user_wr_stb=0100 one cycle.
//  Then write 0x11223344 to base+0x8, BE=0101 -> reg2=DE22BE44; readback returns DE22BE44.
//  Read base+0x10 with status0=0x0BADF00D (NUM_REGS=4) -> DBus=0BADF00D with ack;
//   read base+0x40 -> 0 with ack; ABus outside window -> no ack.
//  C_PULSE_MASK=1, write reg0=0x3 -> bit0 high one cycle then 0, bit1 stays 1.
//  Select held 5 cycles -> exactly one ack; reset asserted in ACK cycle -> ack dropped, regs reset.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB slave exposing PPC-writable control registers and read-only status words
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01060000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010600FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_NUM_STATUS = 2,
    parameter logic [31:0] C_RESET_VAL  = 32'h00000000,
    parameter logic [31:0] C_PULSE_MASK = 32'h00000000
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic                        Sl_xferAck,
    output logic [32*C_NUM_REGS-1:0]    user_data_out,
    output logic [C_NUM_REGS-1:0]       user_wr_stb,
    input  logic [32*C_NUM_STATUS-1:0]  user_status_in
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT
    } state_t;

    state_t state, state_next;

    // OPB numbers bits MSB-first; these copies are in user (LSB-first) order
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] offset;
    logic [29:0] word;
    logic        hit;
    logic        start;
    logic [31:0] rd_next;
    logic [31:0] rd_data_q;
    logic [C_NUM_REGS-1:0][31:0] regs;
    logic        unused_ok;

    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign be     = OPB_BE;
    assign offset = addr - C_BASEADDR;
    assign word   = offset[31:2];
    assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    // a transfer is only accepted from IDLE, so bus changes mid-transfer are ignored
    assign start  = (state == ST_IDLE) && hit;

    // byte lane bits and sequential-address hint carry no information here
    assign unused_ok = ^{OPB_seqAddr, offset[1:0]};

    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign Sl_xferAck    = (state == ST_ACK);
    assign Sl_DBus       = Sl_xferAck ? rd_data_q : 32'h0;
    assign user_data_out = regs;

    // transfer state register
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ack for exactly one cycle, then hold off until the master drops select
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (hit) state_next = ST_ACK;
            ST_ACK:  state_next = ST_WAIT;
            ST_WAIT: if (!OPB_select) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // read mux: control regs first, then status words, everything else reads 0
    always_comb begin
        rd_next = 32'h0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (word == 30'(k)) rd_next = regs[k];
        end
        for (int j = 0; j < C_NUM_STATUS; j++) begin
            if (word == 30'(C_NUM_REGS + j)) rd_next = user_status_in[32*j +: 32];
        end
    end

    // register writes, write strobes, pulse-bit clearing and read data capture
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                regs[k] <= C_RESET_VAL;
            end
            user_wr_stb <= '0;
            rd_data_q   <= 32'h0;
        end else begin
            user_wr_stb <= '0;
            rd_data_q   <= 32'h0;
            // pulse bits fall back one cycle after being set; a write in the same
            // cycle overrides this for the bytes it touches
            regs[0] <= regs[0] & ~C_PULSE_MASK;
            if (start) begin
                if (OPB_RNW) begin
                    rd_data_q <= rd_next;
                end else begin
                    for (int k = 0; k < C_NUM_REGS; k++) begin
                        if (word == 30'(k)) begin
                            user_wr_stb[k] <= 1'b1;
                            for (int b = 0; b < 4; b++) begin
                                if (be[b]) regs[k][8*b +: 8] <= wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - scoreboard bench for the OPB control register bank
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE    = 32'h01060000;
    localparam logic [31:0] HIGH    = 32'h010600FF;
    localparam logic [31:0] RST_VAL = 32'hA5A50000;
    localparam logic [31:0] PMASK   = 32'h00000001;
    localparam int          NR      = 4;
    localparam int          NS      = 2;

    logic          clk;
    logic          rst_n;
    logic [0:31]   abus;
    logic [0:3]    be;
    logic [0:31]   dbus;
    logic          rnw;
    logic          sel;
    logic          seq_addr;
    logic [0:31]   sl_dbus;
    logic          err_ack;
    logic          retry;
    logic          tout_sup;
    logic          xack;
    logic [127:0]  udo;
    logic [3:0]    stb;
    logic [63:0]   status;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (NR),
        .C_NUM_STATUS (NS),
        .C_RESET_VAL  (RST_VAL),
        .C_PULSE_MASK (PMASK)
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .OPB_ABus       (abus),
        .OPB_BE         (be),
        .OPB_DBus       (dbus),
        .OPB_RNW        (rnw),
        .OPB_select     (sel),
        .OPB_seqAddr    (seq_addr),
        .Sl_DBus        (sl_dbus),
        .Sl_errAck      (err_ack),
        .Sl_retry       (retry),
        .Sl_toutSup     (tout_sup),
        .Sl_xferAck     (xack),
        .user_data_out  (udo),
        .user_wr_stb    (stb),
        .user_status_in (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           cyc;
        logic [31:0]  dbus;
        logic [3:0]   stb;
        logic [127:0] regs_ack;
        logic [127:0] regs_after;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [NR];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pack_model();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    // reference model: decides whether the access is acked and what it must look like
    task automatic expect_xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                               input logic [31:0] d);
        exp_t        e;
        logic [31:0] w;
        logic [31:0] v;
        if (a >= BASE && a <= HIGH) begin
            w      = (a - BASE) / 4;
            e.cyc  = cyc + 1;
            e.dbus = 32'h0;
            e.stb  = 4'h0;
            if (r) begin
                if (w < NR) e.dbus = m_regs[w];
                else if (w < NR + NS) e.dbus = status[32*(w-NR) +: 32];
            end else if (w < NR) begin
                v = m_regs[w];
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) v[8*i +: 8] = d[8*i +: 8];
                end
                m_regs[w] = v;
                e.stb = 4'b0001 << w;
            end
            e.regs_ack = pack_model();
            m_regs[0]  = m_regs[0] & ~PMASK;
            e.regs_after = pack_model();
            exp_q.push_back(e);
        end
    endtask

    // one select assertion of 'hold' cycles; bus is scrambled after the first cycle
    task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                        input logic [31:0] d, input int hold);
        expect_xfer(a, r, b, d);
        abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            abus = $urandom; dbus = $urandom; be = 4'($urandom); rnw = 1'($urandom);
        end
        @(posedge clk); #1;
        sel = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // monitor: every ack must match the head of the scoreboard, quiet otherwise
    exp_t         mon_e;
    logic         pend = 1'b0;
    logic [127:0] pend_regs;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("regs_after_ack", udo, pend_regs);
                pend = 1'b0;
            end
            if (xack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 128'(xack), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_cycle", 128'(cyc), 128'(mon_e.cyc));
                    chk("rd_data", 128'(sl_dbus), 128'(mon_e.dbus));
                    chk("wr_stb", 128'(stb), 128'(mon_e.stb));
                    chk("regs_at_ack", udo, mon_e.regs_ack);
                    pend      = 1'b1;
                    pend_regs = mon_e.regs_after;
                end
            end else begin
                chk("idle_dbus", 128'(sl_dbus), 128'(0));
                chk("idle_stb", 128'(stb), 128'(0));
            end
        end
    end

    int          rk;
    logic [31:0] ra;

    initial begin
        rst_n = 1'b0; sel = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; seq_addr = 1'b0;
        status = 64'h0;
        for (int i = 0; i < NR; i++) m_regs[i] = RST_VAL;

        @(posedge clk); @(negedge clk);
        chk("reset_regs", udo, {4{RST_VAL}});
        chk("reset_ack", 128'(xack), 128'(0));
        chk("reset_dbus", 128'(sl_dbus), 128'(0));
        chk("reset_stb", 128'(stb), 128'(0));
        chk("tied_outputs", 128'({err_ack, retry, tout_sup}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'hDEADBEEF, 1);
        chk("full_write_reg2", 128'(udo[95:64]), 128'(32'hDEADBEEF));
        xfer(BASE + 32'h8, 1'b0, 4'b0101, 32'h11223344, 2);
        chk("byte_write_reg2", 128'(udo[95:64]), 128'(32'hDE22BE44));
        xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0, 1);

        status = {32'h12345678, 32'h0BADF00D};
        xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0, 1);
        xfer(BASE + 32'h14, 1'b1, 4'b1111, 32'h0, 2);
        xfer(BASE + 32'h40, 1'b1, 4'b1111, 32'h0, 1);
        xfer(BASE + 32'h40, 1'b0, 4'b1111, 32'hFFFFFFFF, 1);
        xfer(BASE - 32'h4, 1'b1, 4'b1111, 32'h0, 1);
        xfer(HIGH + 32'h1, 1'b1, 4'b1111, 32'h0, 1);
        xfer(HIGH, 1'b1, 4'b1111, 32'h0, 1);

        xfer(BASE, 1'b0, 4'b1111, 32'h00000003, 1);
        chk("pulse_bit_cleared", 128'(udo[31:0]), 128'(32'h00000002));
        xfer(BASE + 32'h4, 1'b0, 4'b0000, 32'hFFFFFFFF, 1);
        xfer(BASE + 32'hC, 1'b0, 4'b1111, 32'hCAFEF00D, 5);

        for (int n = 0; n < 80; n++) begin
            rk = $urandom_range(0, 9);
            if (rk <= 6)      ra = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            else if (rk == 7) ra = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
            else if (rk == 8) ra = BASE - 4 * $urandom_range(1, 1000);
            else              ra = HIGH + 1 + $urandom_range(0, 1000);
            status = {$urandom, $urandom};
            xfer(ra, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom_range(1, 5));
        end

        xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h5A5A5A5A, 1);

        // reset coinciding with the accepting edge: no ack, registers back to reset value
        abus = BASE + 32'h4; rnw = 1'b0; be = 4'b1111; dbus = 32'h77777777; sel = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < NR; i++) m_regs[i] = RST_VAL;
        @(negedge clk);
        chk("reset_abort_regs", udo, {4{RST_VAL}});
        chk("reset_abort_ack", 128'(xack), 128'(0));
        @(posedge clk); #1;

        xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'h600DF00D, 1);

        // reset during the ack cycle: the ack already out stands, state and regs clear
        expect_xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0);
        abus = BASE + 32'h8; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) m_regs[i] = RST_VAL;
        @(negedge clk);
        chk("reset_in_ack_regs", udo, {4{RST_VAL}});
        chk("reset_in_ack_ack", 128'(xack), 128'(0));
        @(posedge clk); #1;

        xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0, 1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
